// File: rtl/comparator_arbiter_pkg.sv
// Shared definitions for the two-requester comparator arbiter.
//   W_DEF   : default operand width in bits
//   state_e : controller state encoding (IDLE, EXEC, DONE)
package comparator_arbiter_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/comparator_arbiter_magnitude_comparator.sv
// Unsigned magnitude comparator (purely combinational).
//   a_i, b_i : operands, W bits, unsigned
//   gt_o     : a_i >  b_i
//   lt_o     : a_i <  b_i
//   eq_o     : a_i == b_i
module magnitude_comparator #(
    parameter int W = comparator_arbiter_pkg::W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator between two requesters.
//   clk, rst             : clock, asynchronous active-high reset
//   req0/a0/b0           : requester 0 request and operands
//   req1/a1/b1           : requester 1 request and operands
//   gnt0, gnt1           : grant, high during EXEC for the owner
//   done0, done1         : one-cycle result-valid pulse for the owner
//   a_gt_b/a_lt_b/a_eq_b : registered result of the last completed compare
//   busy                 : controller not in IDLE
//   op_cnt               : completed compares, modulo 256
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         a_gt_b,
    output logic         a_lt_b,
    output logic         a_eq_b,
    output logic         busy,
    output logic [7:0]   op_cnt
);

    state_e       state_q, state_d;
    // Last (and current) owner; 1 out of reset so requester 0 wins the first tie.
    logic         owner_q, owner_d;
    logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic         done0_q, done0_d, done1_q, done1_d;
    logic         gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic         busy_q, busy_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         take0, take1;
    logic         cmp_gt, cmp_lt, cmp_eq;

    // Round-robin pick: on a tie the requester that did not own last wins.
    assign take0 = req0 && (!req1 || owner_q);
    assign take1 = req1 && (!req0 || !owner_q);

    magnitude_comparator #(.W(W)) u_cmp (
        .a_i  (opa_q),
        .b_i  (opb_q),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand latches carry data only; they are always loaded before use.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 || req1) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        owner_d = owner_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (take0) begin
                    gnt0_d  = 1'b1;
                    owner_d = 1'b0;
                    opa_d   = a0;
                    opb_d   = b0;
                end else if (take1) begin
                    gnt1_d  = 1'b1;
                    owner_d = 1'b1;
                    opa_d   = a1;
                    opb_d   = b1;
                end
            end
            EXEC: begin
                gt_d    = cmp_gt;
                lt_d    = cmp_lt;
                eq_d    = cmp_eq;
                done0_d = !owner_q;
                done1_d = owner_q;
            end
            DONE: begin
                cnt_d = cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign a_gt_b = gt_q;
    assign a_lt_b = lt_q;
    assign a_eq_b = eq_q;
    assign busy   = busy_q;
    assign op_cnt = cnt_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
module tb_comparator_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1;
    logic         a_gt_b, a_lt_b, a_eq_b, busy;
    logic [7:0]   op_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    comparator_arbiter #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset state, before any clock edge
        #2;
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_done", {done1, done0}, 2'b00);
        chk("rst_res", {a_gt_b, a_lt_b, a_eq_b}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", op_cnt, 8'd0);
        step();
        step();
        rst = 1'b0;

        // Single request: 1010 vs 1001
        req0 = 1'b1; a0 = 4'b1010; b0 = 4'b1001;
        step();
        chk("s_gnt", {gnt1, gnt0}, 2'b01);
        chk("s_busy", busy, 1'b1);
        chk("s_done_early", {done1, done0}, 2'b00);
        req0 = 1'b0;
        step();
        chk("s_gnt_drop", {gnt1, gnt0}, 2'b00);
        chk("s_done", {done1, done0}, 2'b01);
        chk("s_res", {a_gt_b, a_lt_b, a_eq_b}, 3'b100);
        chk("s_cnt_mid", op_cnt, 8'd0);
        step();
        chk("s_done_clr", {done1, done0}, 2'b00);
        chk("s_busy_clr", busy, 1'b0);
        chk("s_cnt", op_cnt, 8'd1);

        // Tie after reset: requester 0 first (eq), then requester 1 (lt)
        do_reset();
        req0 = 1'b1; a0 = 4'b1100; b0 = 4'b1100;
        req1 = 1'b1; a1 = 4'b0111; b1 = 4'b1110;
        step();
        chk("t_gnt0", {gnt1, gnt0}, 2'b01);
        step();
        chk("t_done0", {done1, done0}, 2'b01);
        chk("t_res0", {a_gt_b, a_lt_b, a_eq_b}, 3'b001);
        step();
        chk("t_idle", busy, 1'b0);
        req0 = 1'b0;
        step();
        chk("t_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        step();
        chk("t_done1", {done1, done0}, 2'b10);
        chk("t_res1", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);
        step();
        chk("t_cnt", op_cnt, 8'd2);

        // Both held for four compares: grants alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 4'd3; b0 = 4'd2; a1 = 4'd2; b1 = 4'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i % 3 == 0)
                chk($sformatf("rr_gnt%0d", i / 3), {gnt1, gnt0}, ((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_one_gnt", gnt0 & gnt1, 1'b0);
            chk("rr_one_done", done0 & done1, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_cnt", op_cnt, 8'd4);

        // Operand change during EXEC is ignored
        req1 = 1'b1; a1 = 4'b0000; b1 = 4'b0000;
        step();
        chk("oc_gnt1", {gnt1, gnt0}, 2'b10);
        a1 = 4'b1111; req1 = 1'b0;
        step();
        chk("oc_done1", {done1, done0}, 2'b10);
        chk("oc_res", {a_gt_b, a_lt_b, a_eq_b}, 3'b001);
        step();
        chk("oc_cnt", op_cnt, 8'd5);

        // Reset mid-EXEC aborts immediately
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        step();
        chk("ra_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("ra_gnt", {gnt1, gnt0}, 2'b00);
        chk("ra_busy", busy, 1'b0);
        chk("ra_res", {a_gt_b, a_lt_b, a_eq_b}, 3'b000);
        chk("ra_cnt", op_cnt, 8'd0);
        step();
        chk("ra_nodone", {done1, done0}, 2'b00);
        rst = 1'b0;
        step();
        chk("ra_nodone2", {done1, done0}, 2'b00);
        chk("ra_cnt2", op_cnt, 8'd0);
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
        step();
        chk("ra_regnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        step();
        chk("ra_redone", {done1, done0}, 2'b01);
        chk("ra_reres", {a_gt_b, a_lt_b, a_eq_b}, 3'b100);
        step();
        chk("ra_recnt", op_cnt, 8'd1);

        // 256 compares wrap op_cnt to 0, then one more continues
        do_reset();
        req0 = 1'b1;
        for (int i = 0; i < 257; i++) begin
            logic [3:0] ea, eb;
            ea = i[3:0];
            eb = 4'(i * 7 + 3);
            a0 = ea; b0 = eb;
            step();
            chk("wr_gnt", {gnt1, gnt0}, 2'b01);
            step();
            chk("wr_done", {done1, done0}, 2'b01);
            chk("wr_res", {a_gt_b, a_lt_b, a_eq_b}, {ea > eb, ea < eb, ea == eb});
            step();
            if (i == 254) chk("wr_cnt255", op_cnt, 8'd255);
            if (i == 255) chk("wr_cnt_wrap", op_cnt, 8'd0);
            if (i == 256) chk("wr_cnt_after", op_cnt, 8'd1);
        end
        req0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter W, default 4: operand width in bits; equals the magnitude_comparator operand width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 compare request; held high until gnt0.
REQ-005 a0, b0  input  W  requester 0 operands A, B (unsigned).
REQ-006 req1  input  1  requester 1 compare request; held high until gnt1.
REQ-007 a1, b1  input  W  requester 1 operands A, B (unsigned).
REQ-008 gnt0, gnt1  output  1 each  grant; high while that requester owns the comparator.
REQ-009 done0, done1  output  1 each  one-cycle pulse; result valid for that requester.
REQ-010 a_gt_b, a_lt_b, a_eq_b  output  1 each  registered result of the last completed compare.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 op_cnt  output  8  count of completed compares, modulo 256.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; all outputs SHALL be registered.
REQ-014 IDLE with no request: state stays IDLE; gnt0, gnt1, done0, done1 stay low.
REQ-015 IDLE with exactly one request at a rising edge: latch that requester's operands, set owner, assert its gnt, go to EXEC.
REQ-016 IDLE with req0 and req1 both high: grant the requester that is not last_owner (round-robin); set last_owner to the winner.
REQ-017 EXEC at a rising edge: load a_gt_b/a_lt_b/a_eq_b from the comparator on the latched operands; assert owner's done; drop gnt; go to DONE.
REQ-018 DONE at a rising edge: clear done; increment op_cnt; go to IDLE.
REQ-019 Latency: request sampled at edge N gives gnt high after N, result and done high after N+1, done low and busy low after N+2.
REQ-020 Throughput: at most one compare per 3 cycles.
REQ-021 Requests in EXEC or DONE SHALL be ignored, not queued; a held request is arbitrated at the next IDLE edge.
REQ-022 Operand changes after the grant edge SHALL NOT affect the in-flight result.
REQ-023 Exactly one of a_gt_b, a_lt_b, a_eq_b SHALL be high after the first completed compare; the result holds until the next EXEC edge.
REQ-024 At most one gnt and at most one done SHALL be high in any cycle.
REQ-025 op_cnt SHALL wrap from 255 to 0 with no flag.

Reset
REQ-026 On rst high, immediately and regardless of clk: state=IDLE; gnt0, gnt1, done0, done1, busy=0; a_gt_b, a_lt_b, a_eq_b=0; op_cnt=0; last_owner=1, so requester 0 wins the first tie.
REQ-027 Reset during EXEC or DONE SHALL abort the compare with no done pulse and no op_cnt increment.
REQ-028 After rst falls, the first rising edge SHALL behave as IDLE.

Structure
REQ-029 The state encoding (IDLE, EXEC, DONE) and the default W SHALL live in a shared package.
REQ-030 The block SHALL instantiate exactly one magnitude_comparator sub-module, driven from the latched operand registers; no other comparison logic is allowed.

Verification
REQ-031 Reset then req0 with a0=1010, b0=1001 -> gnt0 for 1 cycle; then done0 with a_gt_b=1, a_lt_b=0, a_eq_b=0; op_cnt=1.
REQ-032 req0 and req1 both held high, a0=b0=1100, a1=0111, b1=1110 -> sequence gnt0, done0 (eq=1), gnt1, done1 (lt=1); never both gnts high; op_cnt=2.
REQ-033 Both held high for 4 compares -> grant order 0,1,0,1; op_cnt=4.
REQ-034 Change a1 from 0000 to 1111 during EXEC with b1=0000 -> result a_eq_b=1; the new value is ignored.
REQ-035 Assert rst mid-EXEC -> all outputs 0 immediately; no done pulse; op_cnt=0; next request is served normally.
REQ-036 Run 256 compares -> op_cnt reads 0 and operation continues uninterrupted.
